// File: rtl/vram_arb_pkg.sv
// Shared types and phase encodings for the VRAM slot arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_VDP,
    OWN_AUX,
    OWN_REF
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [1:0] PH_VDP    = 2'b11;
  localparam logic [1:0] PH_SHARED = 2'b00;

endpackage

// File: rtl/vram_refresh_timer.sv
// Cycles-since-refresh counter with due indication and a sticky overdue flag.
module vram_refresh_timer
  import vram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 1560
) (
  input  logic clk,
  input  logic reset_n,
  input  logic refresh_i,
  output logic refresh_due_c,
  output logic refresh_overdue_o
);

  localparam int unsigned CNT_MAX = 2 * REFRESH_INTERVAL;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overdue_q, overdue_d;

  // Saturating count; the flag rises in the same edge the count hits its ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (refresh_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    overdue_d = overdue_q | (cnt_d == CNT_W'(CNT_MAX));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      overdue_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overdue_q <= overdue_d;
    end
  end

  assign refresh_due_c     = (cnt_q >= CNT_W'(REFRESH_INTERVAL));
  assign refresh_overdue_o = overdue_q;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Arbitrates the SDRAM controller between VDP phase slots and one aux master;
// aux borrows the shared (refresh) slot whenever a refresh is not yet due.
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 1560,
  parameter int unsigned ADDR_W           = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vdp_dlclk,
  input  logic              vdp_dhclk,
  input  logic              vdp_we_n,
  input  logic [18:0]       vdp_addr,
  input  logic [7:0]        vdp_wdata,
  output logic [15:0]       vdp_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [15:0]       aux_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din8,
  input  logic              mem_busy,
  input  logic [15:0]       mem_dout16,
  output logic              refresh_overdue
);

  logic [1:0]        phase_q, phase_prev_q;
  logic              vdp_pend_q, vdp_pend_d, shr_pend_q, shr_pend_d;
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              rd_q, rd_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              mem_refresh_q, mem_refresh_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din8_q, mem_din8_d;
  logic [15:0]       vdp_rdata_q, vdp_rdata_d, aux_rdata_q, aux_rdata_d;
  logic              aux_ack_q, aux_ack_d;
  logic              refresh_due;
  logic              slot_edge;

  vram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk              (clk),
    .reset_n          (reset_n),
    .refresh_i        (mem_refresh_q),
    .refresh_due_c    (refresh_due),
    .refresh_overdue_o(refresh_overdue)
  );

  assign slot_edge = (phase_q != phase_prev_q);

  // Command pulses are registered on the select edge so they are visible during ISSUE.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rd_d          = rd_q;
    vdp_pend_d    = vdp_pend_q;
    shr_pend_d    = shr_pend_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_refresh_d = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_din8_d    = mem_din8_q;
    vdp_rdata_d   = vdp_rdata_q;
    aux_rdata_d   = aux_rdata_q;
    aux_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_busy) begin
          if (vdp_pend_q) begin
            vdp_pend_d  = 1'b0;
            owner_d     = OWN_VDP;
            rd_d        = vdp_we_n;
            mem_read_d  = vdp_we_n;
            mem_write_d = !vdp_we_n;
            mem_addr_d  = ADDR_W'(vdp_addr);
            mem_din8_d  = vdp_wdata;
            state_d     = ISSUE;
          end else if (shr_pend_q) begin
            shr_pend_d = 1'b0;
            state_d    = ISSUE;
            if (aux_req && !refresh_due) begin
              owner_d     = OWN_AUX;
              rd_d        = !aux_we;
              mem_read_d  = !aux_we;
              mem_write_d = aux_we;
              mem_addr_d  = aux_addr;
              mem_din8_d  = aux_wdata;
            end else begin
              owner_d       = OWN_REF;
              rd_d          = 1'b0;
              mem_refresh_d = 1'b1;
            end
          end
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (mem_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!mem_busy) begin
          state_d = IDLE;
          if (owner_q == OWN_VDP && rd_q) vdp_rdata_d = mem_dout16;
          if (owner_q == OWN_AUX) begin
            aux_rdata_d = mem_dout16;
            aux_ack_d   = 1'b1;
          end
        end
      end
      default:   state_d = IDLE;
    endcase

    // A fresh slot edge wins over a same-cycle clear.
    if (slot_edge && phase_q == PH_VDP)    vdp_pend_d = 1'b1;
    if (slot_edge && phase_q == PH_SHARED) shr_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= 2'b00;
      phase_prev_q  <= 2'b00;
      vdp_pend_q    <= 1'b0;
      shr_pend_q    <= 1'b0;
      state_q       <= IDLE;
      owner_q       <= OWN_VDP;
      rd_q          <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_din8_q    <= '0;
      vdp_rdata_q   <= '0;
      aux_rdata_q   <= '0;
      aux_ack_q     <= 1'b0;
    end else begin
      phase_q       <= {vdp_dlclk, vdp_dhclk};
      phase_prev_q  <= phase_q;
      vdp_pend_q    <= vdp_pend_d;
      shr_pend_q    <= shr_pend_d;
      state_q       <= state_d;
      owner_q       <= owner_d;
      rd_q          <= rd_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_refresh_q <= mem_refresh_d;
      mem_addr_q    <= mem_addr_d;
      mem_din8_q    <= mem_din8_d;
      vdp_rdata_q   <= vdp_rdata_d;
      aux_rdata_q   <= aux_rdata_d;
      aux_ack_q     <= aux_ack_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_refresh = mem_refresh_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din8    = mem_din8_q;
  assign vdp_rdata   = vdp_rdata_q;
  assign aux_rdata   = aux_rdata_q;
  assign aux_ack     = aux_ack_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter with a simple busy/data controller model.
module tb_vram_slot_arbiter;

  localparam int unsigned RI   = 1560;
  localparam int unsigned AW   = 23;
  localparam int unsigned CMAX = 2 * RI;

  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_REF = 2'd2;
  localparam logic [1:0] K_SHR = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic          own_aux;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } cmd_t;

  typedef struct packed {
    logic        rd;
    logic [15:0] data;
  } ack_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vdp_dlclk = 1'b0, vdp_dhclk = 1'b0, vdp_we_n = 1'b1;
  logic [18:0]   vdp_addr = 19'h12345;
  logic [7:0]    vdp_wdata = 8'h00;
  logic [15:0]   vdp_rdata;
  logic          aux_req = 1'b0, aux_we = 1'b0;
  logic [AW-1:0] aux_addr = '0;
  logic [7:0]    aux_wdata = 8'h00;
  logic          aux_ack;
  logic [15:0]   aux_rdata;
  logic          mem_read, mem_write, mem_refresh;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din8;
  logic          mem_busy = 1'b0;
  logic [15:0]   mem_dout16 = 16'h0000;
  logic          refresh_overdue;

  int checks = 0;
  int failures = 0;

  cmd_t exp_q[$];
  ack_t ack_q[$];
  int   cyc = 0, cmd_cnt = 0, ack_cnt = 0, ref_cnt = 0;
  int   last_cmd_cyc = 0, last_ack_cyc = 0;
  int   m_cnt = 0, m_prev = 0;
  logic ref_prev = 1'b0;
  logic aux_drop = 1'b0;
  int   busy_len = 4;

  vram_slot_arbiter #(
    .REFRESH_INTERVAL(RI),
    .ADDR_W          (AW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vdp_dlclk      (vdp_dlclk),
    .vdp_dhclk      (vdp_dhclk),
    .vdp_we_n       (vdp_we_n),
    .vdp_addr       (vdp_addr),
    .vdp_wdata      (vdp_wdata),
    .vdp_rdata      (vdp_rdata),
    .aux_req        (aux_req),
    .aux_we         (aux_we),
    .aux_addr       (aux_addr),
    .aux_wdata      (aux_wdata),
    .aux_ack        (aux_ack),
    .aux_rdata      (aux_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_refresh    (mem_refresh),
    .mem_addr       (mem_addr),
    .mem_din8       (mem_din8),
    .mem_busy       (mem_busy),
    .mem_dout16     (mem_dout16),
    .refresh_overdue(refresh_overdue)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hBEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Controller model: busy rises the cycle after a pulse, data appears as busy falls.
  logic          cm_pend = 1'b0, cm_rd = 1'b0;
  int            cm_left = 0;
  logic [AW-1:0] cm_addr = '0;
  always @(negedge clk) begin
    if (mem_busy) begin
      cm_left--;
      if (cm_left <= 0) begin
        mem_busy   = 1'b0;
        mem_dout16 = cm_rd ? data_of(cm_addr) : 16'hDEAD;
      end
    end else if (cm_pend) begin
      cm_pend  = 1'b0;
      mem_busy = 1'b1;
      cm_left  = busy_len;
    end
    if (mem_read || mem_write || mem_refresh) begin
      cm_pend = 1'b1;
      cm_rd   = mem_read;
      cm_addr = mem_addr;
    end
  end

  // Monitor: refresh-age model, command scoreboard and ack scoreboard.
  always @(negedge clk) begin
    cmd_t       e;
    ack_t       a;
    logic [1:0] gk;
    cyc++;
    m_prev = m_cnt;
    if (!reset_n || ref_prev) m_cnt = 0;
    else if (m_cnt < int'(CMAX)) m_cnt++;
    ref_prev = reset_n && mem_refresh;

    if (mem_read || mem_write || mem_refresh) begin
      cmd_cnt++;
      last_cmd_cyc = cyc;
      if (mem_refresh) ref_cnt++;
      gk = mem_read ? K_RD : (mem_write ? K_WR : K_REF);
      check_eq("cmd_single", 32'(mem_read) + 32'(mem_write) + 32'(mem_refresh), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("cmd_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_SHR) begin
          if (m_prev >= int'(RI) || !aux_req)
            e = '{kind: K_REF, own_aux: 1'b0, addr: '0, din: '0};
          else
            e = '{kind: (aux_we ? K_WR : K_RD), own_aux: 1'b1, addr: aux_addr, din: aux_wdata};
        end
        check_eq("cmd_kind", 32'(gk), 32'(e.kind));
        if (e.kind != K_REF) check_eq("cmd_addr", 32'(mem_addr), 32'(e.addr));
        if (e.kind == K_WR) check_eq("cmd_din8", 32'(mem_din8), 32'(e.din));
        if (e.own_aux) ack_q.push_back('{rd: (e.kind == K_RD), data: data_of(e.addr)});
      end
    end

    if (aux_ack) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      if (ack_q.size() == 0) begin
        check_eq("ack_unexpected", 32'(ack_q.size()), 32'd1);
      end else begin
        a = ack_q.pop_front();
        if (a.rd) check_eq("aux_rdata", 32'(aux_rdata), 32'(a.data));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (aux_drop && aux_ack) aux_req = 1'b0;
    end
  endtask

  task automatic set_phase(input logic [1:0] ph);
    {vdp_dlclk, vdp_dhclk} = ph;
  endtask

  task automatic push_vdp();
    exp_q.push_back('{kind: K_RD, own_aux: 1'b0, addr: AW'(vdp_addr), din: 8'h00});
  endtask

  task automatic push_shr();
    exp_q.push_back('{kind: K_SHR, own_aux: 1'b0, addr: '0, din: 8'h00});
  endtask

  task automatic run_iter();
    set_phase(2'b11); push_vdp(); tick(8);
    set_phase(2'b01); tick(8);
    push_shr(); set_phase(2'b00); tick(8);
    set_phase(2'b10); tick(8);
  endtask

  task automatic wait_cmd(input string tag, input int budget);
    int start;
    int n;
    start = cmd_cnt;
    n = 0;
    while (cmd_cnt == start && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(cmd_cnt != start), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int start;
    int n;
    start = ack_cnt;
    n = 0;
    while (ack_cnt == start && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(ack_cnt != start), 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_mem_read"},    32'(mem_read), 32'd0);
    check_eq({pfx, "_mem_write"},   32'(mem_write), 32'd0);
    check_eq({pfx, "_mem_refresh"}, 32'(mem_refresh), 32'd0);
    check_eq({pfx, "_mem_addr"},    32'(mem_addr), 32'd0);
    check_eq({pfx, "_mem_din8"},    32'(mem_din8), 32'd0);
    check_eq({pfx, "_aux_ack"},     32'(aux_ack), 32'd0);
    check_eq({pfx, "_aux_rdata"},   32'(aux_rdata), 32'd0);
    check_eq({pfx, "_vdp_rdata"},   32'(vdp_rdata), 32'd0);
    check_eq({pfx, "_overdue"},     32'(refresh_overdue), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0, refs0, iters, post, n;

    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // VDP reads in every 11 slot, refresh in every shared slot.
    for (int i = 0; i < 4; i++) begin
      run_iter();
      check_eq("vdp_rdata", 32'(vdp_rdata), 32'(data_of(AW'(19'h12345))));
    end

    // Single aux write, then the request is withdrawn.
    aux_drop = 1'b1; aux_we = 1'b1; aux_addr = 23'h400000; aux_wdata = 8'hA5; aux_req = 1'b1;
    acks0 = ack_cnt;
    run_iter();
    run_iter();
    check_eq("aux_wr_acks", 32'(ack_cnt - acks0), 32'd1);

    // Aux read at the top of the address space.
    aux_we = 1'b0; aux_addr = 23'h7FFFFF; aux_req = 1'b1;
    acks0 = ack_cnt;
    run_iter();
    check_eq("aux_rd_acks", 32'(ack_cnt - acks0), 32'd1);

    // Continuous aux demand until refresh becomes due.
    aux_drop = 1'b0; aux_we = 1'b1; aux_addr = 23'h400000; aux_wdata = 8'h3C; aux_req = 1'b1;
    refs0 = ref_cnt; acks0 = ack_cnt; iters = 0; post = 0;
    while (post < 2 && iters < 80) begin
      run_iter();
      iters++;
      if (ref_cnt != refs0) post++;
    end
    aux_req = 1'b0;
    tick(8);
    check_eq("starve_one_refresh", 32'(ref_cnt - refs0), 32'd1);
    check_eq("starve_aux_acks", 32'(ack_cnt - acks0), 32'(iters - 1));

    // VDP slot and shared slot both arrive during a long aux access.
    busy_len = 10; aux_drop = 1'b1;
    aux_we = 1'b1; aux_addr = 23'h1FFFFF; aux_wdata = 8'h5A; aux_req = 1'b1;
    push_shr(); set_phase(2'b00);
    wait_cmd("long_aux_issue", 20);
    set_phase(2'b11); push_vdp(); tick(2);
    set_phase(2'b10); tick(2);
    push_shr(); set_phase(2'b00);
    wait_ack("long_aux_ack", 40);
    wait_cmd("vdp_after_aux", 10);
    check_eq("vdp_after_idle_lat", 32'(last_cmd_cyc - last_ack_cyc), 32'd1);
    tick(40);
    busy_len = 4;
    set_phase(2'b10); tick(4);

    // Reset while an aux read sits in WAIT_DONE.
    busy_len = 6; aux_drop = 1'b0;
    aux_we = 1'b0; aux_addr = 23'h0ABCDE; aux_req = 1'b1;
    push_shr(); set_phase(2'b00);
    wait_cmd("rst_aux_issue", 20);
    tick(3);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    ack_q.delete();
    aux_req = 1'b0;
    acks0 = ack_cnt;
    tick(2);
    reset_n = 1'b1;
    tick(30);
    check_eq("midrst_no_ack", 32'(ack_cnt - acks0), 32'd0);
    busy_len = 4;

    // No phase activity: overdue rises exactly at the counter ceiling and sticks.
    n = 0;
    while (m_cnt < int'(CMAX) - 1 && n < 4000) begin
      tick(1);
      n++;
    end
    check_eq("overdue_before", 32'(refresh_overdue), 32'd0);
    tick(1);
    check_eq("overdue_at_max", 32'(refresh_overdue), 32'd1);
    tick(50);
    check_eq("overdue_sticky", 32'(refresh_overdue), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("overdue_reset", 32'(refresh_overdue), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check_eq("overdue_after_rst", 32'(refresh_overdue), 32'd0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_slot_arbiter.md
# vram_slot_arbiter

Shares the single SDRAM memory controller between the VDP and one auxiliary requester, such as a blitter, CPU DMA or audio buffer fill. VDP accesses stay locked to the VDP's DLClk/DHClk phase slots. The aux port is served in the refresh slot whenever a refresh is not due. Sits between the VDP/aux masters and the memory controller's read/write/refresh strobes, in the SDRAM logic clock domain.

## Interface
- REFRESH_INTERVAL, 1560 — clk cycles between required refreshes.
- ADDR_W, 23 — memory word address width.
- clk  in  1  SDRAM logic clock; all inputs synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- vdp_dlclk, vdp_dhclk  in  1 each  VDP phase bits.
- vdp_we_n  in  1  VDP write enable, active low.
- vdp_addr  in  19  VDP address.
- vdp_wdata  in  8  VDP write data.
- vdp_rdata  out  16  last VDP read result.
- aux_req  in  1  level request; held with addr/we/wdata stable until ack.
- aux_we  in  1  1 = write.
- aux_addr  in  ADDR_W  aux address.
- aux_wdata  in  8  aux write data.
- aux_ack  out  1  one-cycle completion pulse.
- aux_rdata  out  16  read data, valid in the aux_ack cycle.
- mem_read, mem_write, mem_refresh  out  1 each  one-cycle command pulses.
- mem_addr  out  ADDR_W  command address; VDP addresses are zero-extended.
- mem_din8  out  8  write data.
- mem_busy  in  1  controller busy; rises the cycle after a command pulse.
- mem_dout16  in  16  controller read data, valid when busy falls.
- refresh_overdue  out  1  sticky error flag, cleared only by reset.

## Operation
- Phase is {dlclk, dhclk}, registered once; a slot starts when the registered phase differs from the previous one.
  - 11 = VDP slot.
  - 00 = shared slot.
  - 01 and 10 = idle.
- VDP slot: set vdp_pend.
- Shared slot: set shr_pend.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- In IDLE with mem_busy=0, select by priority:
  1. vdp_pend: read or write per vdp_we_n.
  2. shr_pend with refresh_due: refresh.
  3. shr_pend with aux_req: aux access.
  4. shr_pend with neither: refresh.
- Selecting an owner clears its pend flag and latches owner (VDP/AUX/REF). The next state is ISSUE.
- ISSUE: drive exactly one mem_* pulse plus address/data, then go to WAIT_BUSY.
- WAIT_BUSY: wait for mem_busy=1, then go to WAIT_DONE.
- WAIT_DONE: on mem_busy=0:
  - VDP read: capture vdp_rdata.
  - AUX: capture aux_rdata and pulse aux_ack (writes ack too).
  - Return to IDLE.
- Refresh counter: increments every cycle and saturates at 2·REFRESH_INTERVAL. It clears in the cycle mem_refresh pulses.
  - refresh_due = cnt ≥ REFRESH_INTERVAL.
  - refresh_overdue sets when cnt reaches 2·REFRESH_INTERVAL.
- Starvation bound: aux is refused a shared slot only while refresh is due, and the refresh clears due. Aux is therefore deferred by at most one shared slot.
- Simultaneous events:
  - A new VDP slot arriving during any access sets vdp_pend and is served next, ahead of shr_pend.
  - A slot edge arriving while its pend flag is already set is absorbed; no counter, no error.
  - aux_req deasserting before ack is illegal; behaviour is undefined and not checked.
- Reset mid-operation: all state clears immediately. An in-flight aux access is never acked and the requester re-requests.

## Timing
- Reset values: all mem_* = 0, aux_ack = 0, vdp_rdata = 0, aux_rdata = 0, refresh_overdue = 0, counter = 0, state IDLE, pend flags 0.
- Phase edge to command pulse with the controller idle: 3 cycles (register, edge/pend, IDLE select, then the ISSUE pulse lands in the third cycle).
- Busy fall to rdata/ack update: 1 cycle, registered.
- mem_addr and mem_din8 hold their values from ISSUE until the next ISSUE.
- At most one command is outstanding; a new command is never issued while mem_busy=1.

## Structure
- Package vram_arb_pkg holds:
  - typedef owner_t {OWN_VDP, OWN_AUX, OWN_REF};
  - typedef state_t;
  - localparams PH_VDP = 2'b11 and PH_SHARED = 2'b00.
- One sub-module: vram_refresh_timer, which owns the counter, refresh_due and refresh_overdue. Its inputs are the refresh pulse and reset.
- Everything else is a single always_ff FSM plus registered outputs in vram_slot_arbiter.

## Test plan
- Phase sequence 11→01→00→10 repeated, VDP read of addr 0x12345, aux idle, controller model busy 4 cycles:
  - one mem_read with mem_addr=0x012345 per cycle of the sequence;
  - mem_refresh in every shared slot;
  - vdp_rdata equals the model data.
- aux_req write, addr 0x400000, data 0xA5, with refresh not due:
  - mem_write issued in the next shared slot with mem_addr=0x400000 and mem_din8=0xA5;
  - aux_ack pulses exactly once.
- Hold aux_req continuously until the counter reaches REFRESH_INTERVAL:
  - that shared slot issues mem_refresh and the counter clears;
  - the following shared slot serves aux.
- VDP slot edge while the aux access is busy for 10 cycles:
  - VDP command issues 1 cycle after IDLE is re-entered, before any pending shared slot.
- Stop phase toggling for 2·REFRESH_INTERVAL cycles:
  - refresh_overdue = 1 and stays 1 until reset_n is pulsed.
- Assert reset_n=0 during WAIT_DONE of an aux read:
  - all outputs read 0 within the same cycle;
  - no aux_ack occurs after release.
